decoder_seq_ctrl: RTL and testbench

Sequencer for the constant-weight decoder core. It accepts 10-bit codeword symbols from an upstream valid/ready source and writes exactly N_WORDS of them into the decoder's symbol buffer. It then pulses the decoder's start and deserializes the decoder's serial binary output into bytes. Bytes pass through a small show-ahead FIFO to a downstream valid/ready sink. It sits between the link/packet layer and `decoder_top`.

---
 rtl/decoder_seq_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_decoder_seq_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_seq_ctrl.sv
// Sequencer for the constant-weight decoder: loads N_WORDS symbols, kicks the decoder,
// packs its serial output into bytes and hands them downstream through a show-ahead FIFO.
module decoder_seq_ctrl #(
    parameter int WORD_W     = 10,
    parameter int N_WORDS    = 38,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_word,
    output logic              in_ready,
    output logic              dec_wr_en,
    output logic [WORD_W-1:0] dec_msg_byte,
    output logic              dec_start,
    input  logic              dec_bin_msg,
    input  logic              dec_msg_rdy,
    input  logic              dec_msg_done,
    output logic              out_valid,
    output logic [7:0]        out_byte,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic [15:0]       bit_total
);
    localparam int WCW = $clog2(N_WORDS);
    localparam int AW  = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_FLUSH, S_DRAIN} state_t;

    state_t                       state_q, state_d;
    logic [WCW-1:0]               word_cnt_q, word_cnt_d;
    logic [2:0]                   bit_cnt_q, bit_cnt_d;
    logic [7:0]                   shreg_q, shreg_d;
    logic [15:0]                  bit_total_q, bit_total_d;
    logic                         wr_en_q, wr_en_d;
    logic [WORD_W-1:0]            msg_q, msg_d;
    logic                         start_q, start_d;
    logic                         push_q, push_d;
    logic [7:0]                   push_byte_q, push_byte_d;
    logic                         err_q, err_d;
    logic [AW:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH-1:0][7:0]   mem_q, mem_d;
    logic                         fifo_empty, fifo_full, pop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && out_ready;

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        bit_total_d = bit_total_q;
        wr_en_d     = 1'b0;
        msg_d       = msg_q;
        start_d     = 1'b0;
        push_d      = 1'b0;
        push_byte_d = push_byte_q;
        err_d       = err_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_d       = mem_q;
        done        = 1'b0;

        // A push into a full FIFO only survives if the head leaves in the same cycle.
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_q) begin
            if (!fifo_full || pop) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_byte_q;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: state_d = S_LOAD;
            S_LOAD: begin
                if (in_valid) begin
                    msg_d   = in_word;
                    wr_en_d = 1'b1;
                    if (word_cnt_q == WCW'(N_WORDS - 1)) begin
                        word_cnt_d = '0;
                        state_d    = S_START;
                    end else begin
                        word_cnt_d = word_cnt_q + WCW'(1);
                    end
                end
            end
            S_START: begin
                start_d     = 1'b1;
                bit_total_d = '0;
                bit_cnt_d   = '0;
                state_d     = S_RUN;
            end
            S_RUN: begin
                if (dec_msg_rdy) begin
                    shreg_d   = {shreg_q[6:0], dec_bin_msg};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_total_q != 16'hFFFF)
                        bit_total_d = bit_total_q + 16'd1;
                    if (bit_cnt_q == 3'd7) begin
                        push_d      = 1'b1;
                        push_byte_d = shreg_d;
                    end
                end
                if (dec_msg_done)
                    state_d = (bit_cnt_d == 3'd0) ? S_DRAIN : S_FLUSH;
            end
            S_FLUSH: begin
                push_d      = 1'b1;
                push_byte_d = shreg_q << (4'd8 - {1'b0, bit_cnt_q});
                bit_cnt_d   = '0;
                state_d     = S_DRAIN;
            end
            S_DRAIN: begin
                // A byte still in flight to the FIFO counts as not drained.
                if (fifo_empty && !push_q) begin
                    done    = 1'b1;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d     = S_LOAD;
            word_cnt_d  = '0;
            bit_cnt_d   = '0;
            bit_total_d = bit_total_q;
            err_d       = 1'b0;
            wr_en_d     = 1'b0;
            start_d     = 1'b0;
            push_d      = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            done        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q     <= S_IDLE;
            word_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            bit_total_q <= '0;
            wr_en_q     <= 1'b0;
            msg_q       <= '0;
            start_q     <= 1'b0;
            push_q      <= 1'b0;
            push_byte_q <= '0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_q       <= '0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            bit_total_q <= bit_total_d;
            wr_en_q     <= wr_en_d;
            msg_q       <= msg_d;
            start_q     <= start_d;
            push_q      <= push_d;
            push_byte_q <= push_byte_d;
            err_q       <= err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
        end
    end

    assign in_ready     = (state_q == S_LOAD);
    assign dec_wr_en    = wr_en_q;
    assign dec_msg_byte = msg_q;
    assign dec_start    = start_q;
    assign out_valid    = !fifo_empty;
    assign out_byte     = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign busy         = (state_q != S_IDLE && state_q != S_LOAD) || (word_cnt_q != '0);
    assign err_overflow = err_q;
    assign bit_total    = bit_total_q;
endmodule

// File: tb/tb_decoder_seq_ctrl.sv
// Directed bench for decoder_seq_ctrl: load/start timing, bit packing, padding, overflow, abort, reset.
module tb_decoder_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_b = 1'b1;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic [9:0] in_word = '0;
    logic       in_ready, dec_wr_en, dec_start, out_valid, busy, done, err_overflow;
    logic [9:0] dec_msg_byte;
    logic       dec_bin_msg = 1'b0, dec_msg_rdy = 1'b0, dec_msg_done = 1'b0;
    logic [7:0] out_byte;
    logic       out_ready = 1'b0;
    logic [15:0] bit_total;

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [7:0] got[$];
    logic [9:0] w[38];

    decoder_seq_ctrl #(.WORD_W(10), .N_WORDS(38), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_b(rst_b), .abort(abort),
        .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
        .dec_wr_en(dec_wr_en), .dec_msg_byte(dec_msg_byte), .dec_start(dec_start),
        .dec_bin_msg(dec_bin_msg), .dec_msg_rdy(dec_msg_rdy), .dec_msg_done(dec_msg_done),
        .out_valid(out_valid), .out_byte(out_byte), .out_ready(out_ready),
        .busy(busy), .done(done), .err_overflow(err_overflow), .bit_total(bit_total)
    );

    always #5 clk = ~clk;

    // Inputs only change 2ns after a rising edge, so the falling edge sees stable values.
    always @(negedge clk) begin
        if (!rst_b) begin
            if (out_valid && out_ready) got.push_back(out_byte);
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load_words(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            chk("in_ready_load", in_ready, 1);
            in_valid = 1'b1;
            in_word  = w[first + i];
            step();
            chk("wr_en", dec_wr_en, 1);
            chk("wr_data", dec_msg_byte, w[first + i]);
            chk("start_in_burst", dec_start, 0);
        end
        in_valid = 1'b0;
    endtask

    task automatic start_pulse();
        step();
        chk("wr_en_after", dec_wr_en, 0);
        chk("start_hi", dec_start, 1);
        chk("bit_total_clr", bit_total, 0);
        step();
        chk("start_lo", dec_start, 0);
        chk("busy_run", busy, 1);
    endtask

    task automatic send_bits(input logic [63:0] b, input int n, input bit fin);
        for (int j = 0; j < n; j++) begin
            dec_msg_rdy  = 1'b1;
            dec_bin_msg  = b[n-1-j];
            dec_msg_done = fin && (j == n - 1);
            step();
        end
        dec_msg_rdy  = 1'b0;
        dec_msg_done = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 200 && done_cnt < target; k++) step();
        chk("done_seen", done_cnt, target);
        chk("in_ready_after_done", in_ready, 1);
    endtask

    initial begin
        for (int i = 0; i < 38; i++) w[i] = 10'((i * 29 + 3) % 1024);
        w[0] = 10'd2; w[1] = 10'd0; w[2] = 10'd0; w[3] = 10'd6; w[4] = 10'd6; w[5] = 10'd5;
        w[36] = 10'd15; w[37] = 10'd15;

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", dec_wr_en, 0);
        chk("rst_msg", dec_msg_byte, 0);
        chk("rst_start", dec_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_byte", out_byte, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_overflow, 0);
        chk("rst_bit_total", bit_total, 0);
        rst_b = 1'b0;
        #1 chk("idle_in_ready", in_ready, 0);
        step();
        step();
        chk("in_ready_2nd_edge", in_ready, 1);

        // Message 1: two full bytes
        out_ready = 1'b1;
        load_words(0, 38);
        start_pulse();
        send_bits(64'hA5F0, 16, 1'b1);
        wait_done(1);
        chk("m1_nbytes", got.size(), 2);
        if (got.size() == 2) begin
            chk("m1_b0", got[0], 8'hA5);
            chk("m1_b1", got[1], 8'hF0);
        end
        chk("m1_bit_total", bit_total, 16);
        chk("m1_busy", busy, 0);
        got.delete();

        // Message 2: 11 bits, last byte zero padded
        load_words(0, 38);
        start_pulse();
        send_bits(64'h52E, 11, 1'b1);
        wait_done(2);
        chk("m2_nbytes", got.size(), 2);
        if (got.size() == 2) begin
            chk("m2_b0", got[0], 8'hA5);
            chk("m2_b1", got[1], 8'hC0);
        end
        chk("m2_bit_total", bit_total, 11);
        got.delete();

        // Message 3: five bytes into a stalled four-entry FIFO
        out_ready = 1'b0;
        load_words(0, 38);
        start_pulse();
        send_bits(64'h1122334455, 40, 1'b1);
        repeat (5) step();
        chk("m3_err", err_overflow, 1);
        chk("m3_valid", out_valid, 1);
        chk("m3_head", out_byte, 8'h11);
        chk("m3_no_done", done_cnt, 2);
        out_ready = 1'b1;
        wait_done(3);
        chk("m3_nbytes", got.size(), 4);
        if (got.size() == 4) begin
            chk("m3_b0", got[0], 8'h11);
            chk("m3_b1", got[1], 8'h22);
            chk("m3_b2", got[2], 8'h33);
            chk("m3_b3", got[3], 8'h44);
        end
        chk("m3_err_sticky", err_overflow, 1);
        chk("m3_bit_total", bit_total, 40);
        got.delete();

        // Abort partway through a load
        load_words(0, 20);
        chk("pre_abort_busy", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_err", err_overflow, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_bit_total", bit_total, 40);
        chk("abort_wr_en", dec_wr_en, 0);
        load_words(0, 37);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("no_start_37", dec_start, 0);
            chk("still_load", in_ready, 1);
        end
        load_words(37, 1);
        start_pulse();

        // Asynchronous reset in the middle of RUN
        send_bits(64'h5, 3, 1'b0);
        rst_b = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_bit_total", bit_total, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_start", dec_start, 0);
        #1 rst_b = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
